timer_dev: RTL and testbench

Memory-mapped countdown timer responding to the data-side bus, at the far end from the CPU's byte-enable generator. Decodes word offset and byte enables from the memory stage, updates its registers on stores, returns register contents on loads, and raises an interrupt request to the CP0 when the count expires. Two instances sit behind the bridge, at 0x7f00 and 0x7f10. The bridge performs the address select.

---
 rtl/timer_dev.sv | 140 ++++++++++++++
 tb/tb_timer_dev.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers and an expiry interrupt.
// Define TIMER_BYTE_WRITE_EN to make CTRL and PRESET honour per-lane byte enables.
module timer_dev #(
  parameter logic [31:0] PRESET_RST = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;
  localparam int unsigned NB = 4;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] MODE_AUTO   = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   ctrl_q, ctrl_d;
  logic [DW-1:0]   preset_q, preset_d;
  logic [DW-1:0]   count_q, count_d;
  logic            flag_q, flag_d;
  logic            irq_q, irq_d;

  logic            wr_c;
  logic            wr_ctrl_c;
  logic            wr_preset_c;
  logic            en_c;
  logic [1:0]      mode_c;
  logic            im_c;

  assign wr_c        = we && (be != '0);
  assign wr_ctrl_c   = wr_c && (addr == ADDR_CTRL);
  assign wr_preset_c = wr_c && (addr == ADDR_PRESET);
  assign en_c        = ctrl_q[0];
  assign mode_c      = ctrl_q[2:1];
  assign im_c        = ctrl_q[3];

  // Next-state: timer FSM first, then bus stores so a store overrides the INT auto-clear.
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;
    irq_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (en_c) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en_c) begin
          state_d = ST_IDLE;
        end else if (count_q <= DW'(1)) begin
          count_d = '0;
          state_d = ST_INT;
        end else begin
          count_d = count_q - DW'(1);
        end
      end
      ST_INT: begin
        if (mode_c == MODE_AUTO) begin
          state_d = ST_LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          flag_d    = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef TIMER_BYTE_WRITE_EN
    if (wr_ctrl_c && be[0]) ctrl_d = wdata[CW-1:0];
    if (wr_preset_c) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (be[i]) preset_d[8*i +: 8] = wdata[8*i +: 8];
      end
    end
`else
    if (wr_ctrl_c)   ctrl_d   = wdata[CW-1:0];
    if (wr_preset_c) preset_d = wdata;
`endif

    if (wr_ctrl_c || wr_preset_c) flag_d = 1'b0;

    irq_d = im_c & ((state_d == ST_INT) | flag_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= '0;
      preset_q <= PRESET_RST;
      count_q  <= '0;
      flag_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
      irq_q    <= irq_d;
    end
  end

  // Load data is combinational so the memory stage samples it in the access cycle.
  always_comb begin
    rdata = '0;
    unique case (addr)
      ADDR_CTRL:   rdata = DW'(ctrl_q);
      ADDR_PRESET: rdata = preset_q;
      ADDR_COUNT:  rdata = count_q;
      default:     rdata = '0;
    endcase
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_timer_dev.sv
// Directed self-checking bench for timer_dev; follows TIMER_BYTE_WRITE_EN if defined.
module tb_timer_dev;

  localparam logic [31:0] RST_VAL = 32'h0000_00A5;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int unsigned passed;
  int unsigned total;

  timer_dev #(.PRESET_RST(RST_VAL)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .be    (be),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n active edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One store; returns 1 unit after the edge that performs it.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
    addr = a; wdata = d; be = b; we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0; be = 4'h0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    rd(2'd0, d); total++;
    if (d !== 32'h0) $display("FAIL reset_ctrl: got %h want %h", d, 32'h0); else passed++;
    rd(2'd1, d); total++;
    if (d !== RST_VAL) $display("FAIL reset_preset: got %h want %h", d, RST_VAL); else passed++;
    rd(2'd2, d); total++;
    if (d !== 32'h0) $display("FAIL reset_count: got %h want %h", d, 32'h0); else passed++;
    rd(2'd3, d); total++;
    if (d !== 32'h0) $display("FAIL reset_off3: got %h want %h", d, 32'h0); else passed++;
    total++;
    if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else passed++;
  endtask

  task automatic test_regs;
    logic [31:0] d;
    bus_write(2'd1, 32'd5, 4'hF);
    rd(2'd1, d); total++;
    if (d !== 32'd5) $display("FAIL preset_wr: got %h want %h", d, 32'd5); else passed++;
    bus_write(2'd0, 32'hFFFF_FFF6, 4'hF);
    rd(2'd0, d); total++;
    if (d !== 32'h6) $display("FAIL ctrl_upper_zero: got %h want %h", d, 32'h6); else passed++;
    bus_write(2'd0, 32'h0, 4'hF);
    bus_write(2'd1, 32'd7, 4'h0);
    rd(2'd1, d); total++;
    if (d !== 32'd5) $display("FAIL be0_blocks: got %h want %h", d, 32'd5); else passed++;
    bus_write(2'd2, 32'h1234, 4'hF);
    rd(2'd2, d); total++;
    if (d !== 32'h0) $display("FAIL count_ro_idle: got %h want %h", d, 32'h0); else passed++;
    bus_write(2'd3, 32'hFFFF_FFFF, 4'hF);
    rd(2'd3, d); total++;
    if (d !== 32'h0) $display("FAIL off3_reads0: got %h want %h", d, 32'h0); else passed++;
  endtask

  task automatic test_one_shot;
    logic [31:0] d;
    logic [31:0] exp;
    bus_write(2'd1, 32'd5, 4'hF);
    bus_write(2'd0, 32'h9, 4'hF);       // edge E
    step(2);                            // E+2
    for (int i = 0; i < 5; i++) begin
      if (i != 0) step(1);
      exp = 32'd5 - 32'(i);
      rd(2'd2, d); total++;
      if (d !== exp) $display("FAIL os_count[%0d]: got %h want %h", i, d, exp); else passed++;
      total++;
      if (irq !== 1'b0) $display("FAIL os_irq_low[%0d]: got %b want 0", i, irq); else passed++;
    end
    step(1);                            // E+7
    total++;
    if (irq !== 1'b1) $display("FAIL os_irq_rise: got %b want 1", irq); else passed++;
    rd(2'd2, d); total++;
    if (d !== 32'h0) $display("FAIL os_count_zero: got %h want %h", d, 32'h0); else passed++;
    step(4);
    total++;
    if (irq !== 1'b1) $display("FAIL os_irq_held: got %b want 1", irq); else passed++;
    rd(2'd0, d); total++;
    if (d !== 32'h8) $display("FAIL os_en_cleared: got %h want %h", d, 32'h8); else passed++;
    bus_write(2'd0, 32'h0, 4'hF);
    total++;
    if (irq !== 1'b0) $display("FAIL os_irq_clear: got %b want 0", irq); else passed++;
  endtask

  task automatic test_auto_reload;
    logic [31:0] d;
    logic        exp;
    bus_write(2'd1, 32'd3, 4'hF);
    bus_write(2'd0, 32'hB, 4'hF);       // edge E
    for (int c = 1; c <= 16; c++) begin
      step(1);
      exp = (c == 5) || (c == 10) || (c == 15);
      total++;
      if (irq !== exp) $display("FAIL ar_irq[E+%0d]: got %b want %b", c, irq, exp); else passed++;
    end
    rd(2'd0, d); total++;
    if (d !== 32'hB) $display("FAIL ar_en_kept: got %h want %h", d, 32'hB); else passed++;
    bus_write(2'd0, 32'h0, 4'hF);
    step(3);
    total++;
    if (irq !== 1'b0) $display("FAIL ar_stopped_irq: got %b want 0", irq); else passed++;
  endtask

  task automatic test_count_mid;
    logic [31:0] d;
    bus_write(2'd1, 32'd4, 4'hF);
    bus_write(2'd0, 32'h3, 4'hF);       // edge E, auto-reload, masked
    step(3);                            // E+3
    rd(2'd2, d); total++;
    if (d !== 32'd3) $display("FAIL mid_count_e3: got %h want %h", d, 32'd3); else passed++;
    bus_write(2'd2, 32'hFFFF, 4'hF);    // E+4
    rd(2'd2, d); total++;
    if (d !== 32'd2) $display("FAIL mid_count_wr_drop: got %h want %h", d, 32'd2); else passed++;
    bus_write(2'd1, 32'd2, 4'hF);       // E+5
    rd(2'd2, d); total++;
    if (d !== 32'd1) $display("FAIL mid_preset_no_effect: got %h want %h", d, 32'd1); else passed++;
    step(3);                            // E+8: reloaded from new PRESET
    rd(2'd2, d); total++;
    if (d !== 32'd2) $display("FAIL mid_new_preset_reload: got %h want %h", d, 32'd2); else passed++;
    bus_write(2'd0, 32'h0, 4'hF);       // E+9, one more decrement
    step(3);
    rd(2'd2, d); total++;
    if (d !== 32'd1) $display("FAIL mid_freeze: got %h want %h", d, 32'd1); else passed++;
    bus_write(2'd0, 32'h1, 4'hF);       // edge F, restart
    step(2);
    rd(2'd2, d); total++;
    if (d !== 32'd2) $display("FAIL mid_restart_load: got %h want %h", d, 32'd2); else passed++;
    step(3);                            // F+5
    rd(2'd0, d); total++;
    if (d !== 32'h0) $display("FAIL mid_oneshot_en_clr: got %h want %h", d, 32'h0); else passed++;
    total++;
    if (irq !== 1'b0) $display("FAIL mid_masked_irq: got %b want 0", irq); else passed++;
  endtask

  task automatic test_preset_zero;
    logic [31:0] d;
    bus_write(2'd1, 32'd0, 4'hF);
    bus_write(2'd0, 32'h9, 4'hF);       // edge E
    step(2);
    rd(2'd2, d); total++;
    if (d !== 32'h0) $display("FAIL pz_count: got %h want %h", d, 32'h0); else passed++;
    total++;
    if (irq !== 1'b0) $display("FAIL pz_irq_e2: got %b want 0", irq); else passed++;
    step(1);
    total++;
    if (irq !== 1'b1) $display("FAIL pz_irq_e3: got %b want 1", irq); else passed++;
    bus_write(2'd0, 32'h0, 4'hF);
    step(1);
  endtask

  task automatic test_ctrl_at_int;
    logic [31:0] d;
    bus_write(2'd1, 32'd1, 4'hF);
    bus_write(2'd0, 32'h9, 4'hF);       // edge E
    step(3);                            // E+3: INT
    total++;
    if (irq !== 1'b1) $display("FAIL ci_irq_int: got %b want 1", irq); else passed++;
    bus_write(2'd0, 32'h9, 4'hF);       // E+4, same edge as auto-clear
    rd(2'd0, d); total++;
    if (d !== 32'h9) $display("FAIL ci_write_wins: got %h want %h", d, 32'h9); else passed++;
    total++;
    if (irq !== 1'b0) $display("FAIL ci_flag_cleared: got %b want 0", irq); else passed++;
    step(3);                            // E+7: INT again
    total++;
    if (irq !== 1'b1) $display("FAIL ci_rerun_irq: got %b want 1", irq); else passed++;
    bus_write(2'd0, 32'h0, 4'hF);
    step(1);
  endtask

  task automatic test_byte_write;
    logic [31:0] d;
    logic [31:0] exp;
    bus_write(2'd1, 32'h1122_3344, 4'hF);
    bus_write(2'd1, 32'hAABB_CCDD, 4'b0010);
`ifdef TIMER_BYTE_WRITE_EN
    exp = 32'h1122_CC44;
`else
    exp = 32'hAABB_CCDD;
`endif
    rd(2'd1, d); total++;
    if (d !== exp) $display("FAIL byte_write: got %h want %h", d, exp); else passed++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    bus_write(2'd1, 32'd10, 4'hF);
    bus_write(2'd0, 32'h9, 4'hF);       // edge E
    step(5);                            // E+5: COUNT=7
    rd(2'd2, d); total++;
    if (d !== 32'd7) $display("FAIL rm_count7: got %h want %h", d, 32'd7); else passed++;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    rd(2'd2, d); total++;
    if (d !== 32'h0) $display("FAIL rm_count: got %h want %h", d, 32'h0); else passed++;
    rd(2'd0, d); total++;
    if (d !== 32'h0) $display("FAIL rm_ctrl: got %h want %h", d, 32'h0); else passed++;
    rd(2'd1, d); total++;
    if (d !== RST_VAL) $display("FAIL rm_preset: got %h want %h", d, RST_VAL); else passed++;
    total++;
    if (irq !== 1'b0) $display("FAIL rm_irq: got %b want 0", irq); else passed++;
    step(3);
    rd(2'd2, d); total++;
    if (d !== 32'h0) $display("FAIL rm_idle_hold: got %h want %h", d, 32'h0); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b1;
    we     = 1'b0;
    addr   = 2'd0;
    be     = 4'h0;
    wdata  = 32'h0;
    step(2);
    reset = 1'b0;
    test_reset;
    test_regs;
    test_one_shot;
    test_auto_reload;
    test_count_mid;
    test_preset_zero;
    test_ctrl_at_int;
    test_byte_write;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
